// File: rtl/sipo_rx_ctrl_if.sv
// Word handshake between sipo_rx_ctrl and its consumer.
// Master presents word/valid, slave returns ready.
interface sipo_rx_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output word_out,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/sipo_rx_ctrl.sv
// Serial frame receiver that sequences an external SIPO register.
// Captures each assembled word into a one-entry valid/ready output.
module sipo_rx_ctrl #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_serial,
  input  logic             fill_req,
  input  logic [WIDTH-1:0] sipo_data_out,
  output logic             sipo_enable,
  output logic             sipo_data_in,
  output logic             sipo_set_all_ones,
  sipo_rx_ctrl_if.master   word_if,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST    = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_FILL
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bit;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_rx_prev;
  logic             r_en;
  logic             r_din;
  logic             r_set1;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;
  logic             r_busy;
  logic             w_edge;
  logic             w_take;

  assign w_edge = r_rx_prev & ~r_rx_s;
  assign w_take = r_valid & word_if.word_ready;

  assign sipo_enable        = r_en;
  assign sipo_data_in       = r_din;
  assign sipo_set_all_ones  = r_set1;
  assign word_if.word_out   = r_word;
  assign word_if.word_valid = r_valid;
  assign frame_err          = r_ferr;
  assign overrun            = r_ovr;
  assign busy               = r_busy;

  // Line sync, frame FSM, strobes and output word register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_en      <= 1'b0;
      r_din     <= 1'b0;
      r_set1    <= 1'b0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rx_meta <= rx_serial;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      r_en      <= 1'b0;
      r_set1    <= 1'b0;
      r_ferr    <= 1'b0;
      if (w_take) r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_edge) begin
            r_state <= S_START;
            r_bit   <= '0;
            r_busy  <= 1'b1;
          end else if (fill_req) begin
            r_state <= S_FILL;
            r_set1  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            r_en  <= 1'b1;
            r_din <= r_rx_s;
            r_bit <= r_bit + 1'b1;
            if (r_bit == LAST) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (r_rx_s) begin
              if (!r_valid || word_if.word_ready) begin
                r_word  <= sipo_data_out;
                r_valid <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FILL: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl with a 4-bit SIPO model.
// Frames are driven bit-serially; events are tallied on negedge.
module tb_sipo_rx_ctrl;
  localparam int W   = 4;
  localparam int CPB = 8;

  logic         clk;
  logic         reset;
  logic         rx_serial;
  logic         fill_req;
  logic [W-1:0] sipo_q = '0;
  logic         sipo_enable;
  logic         sipo_data_in;
  logic         sipo_set_all_ones;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  sipo_rx_ctrl_if #(.WIDTH(W)) wif ();

  sipo_rx_ctrl #(
    .WIDTH(W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_serial(rx_serial),
    .fill_req(fill_req),
    .sipo_data_out(sipo_q),
    .sipo_enable(sipo_enable),
    .sipo_data_in(sipo_data_in),
    .sipo_set_all_ones(sipo_set_all_ones),
    .word_if(wif),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sipo_set_all_ones) sipo_q <= '1;
    else if (sipo_enable) sipo_q <= {sipo_q[W-2:0], sipo_data_in};
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int en_cnt = 0;
  int en_time [64];
  int set_cnt = 0;
  int set_en_cnt = 0;
  int ferr_cnt = 0;
  int busy_cnt = 0;
  int vld_cyc = 0;
  int vld_rise = 0;
  logic vld_prev = 1'b0;
  logic [W-1:0] cap_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sipo_enable) begin
      en_time[en_cnt % 64] = cyc;
      en_cnt++;
    end
    if (sipo_set_all_ones) begin
      set_cnt++;
      if (sipo_enable) set_en_cnt++;
    end
    if (frame_err) ferr_cnt++;
    if (busy) busy_cnt++;
    if (wif.word_valid) begin
      vld_cyc++;
      if (!vld_prev) begin
        vld_rise++;
        cap_word = wif.word_out;
      end
    end
    vld_prev = wif.word_valid;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d,
                            input logic stop,
                            input bit fill_edge,
                            input int abort_en);
    int e0;
    logic b;
    e0 = en_cnt;
    for (int c = 0; c < (W + 2) * CPB; c++) begin
      if (c < CPB) b = 1'b0;
      else if (c < (W + 1) * CPB) b = d[W - 1 - (c / CPB - 1)];
      else b = stop;
      rx_serial = b;
      fill_req = fill_edge && (c == 2);
      @(posedge clk);
      #1;
      if (abort_en > 0 && en_cnt - e0 >= abort_en) return;
    end
    rx_serial = 1'b1;
    fill_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"}, 32'(sipo_enable), 0);
    chk({tag, "_din"}, 32'(sipo_data_in), 0);
    chk({tag, "_set1"}, 32'(sipo_set_all_ones), 0);
    chk({tag, "_vld"}, 32'(wif.word_valid), 0);
    chk({tag, "_word"}, 32'(wif.word_out), 0);
    chk({tag, "_ferr"}, 32'(frame_err), 0);
    chk({tag, "_ovr"}, 32'(overrun), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int e0;
    int v0;
    int c0;
    int f0;
    int s0;
    int b0;
    reset = 1'b0;
    rx_serial = 1'b1;
    fill_req = 1'b0;
    wif.word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    e0 = en_cnt; v0 = vld_rise; c0 = vld_cyc; f0 = ferr_cnt;
    send_frame(4'b1011, 1'b1, 1'b0, 0);
    chk("basic_en_cnt", 32'(en_cnt - e0), 4);
    for (int i = 1; i < 4; i++)
      chk("basic_en_gap",
          32'(en_time[(e0 + i) % 64] - en_time[(e0 + i - 1) % 64]), CPB);
    chk("basic_word", 32'(cap_word), 32'hb);
    chk("basic_vld_rise", 32'(vld_rise - v0), 1);
    chk("basic_vld_cyc", 32'(vld_cyc - c0), 1);
    chk("basic_ferr", 32'(ferr_cnt - f0), 0);
    chk("basic_ovr", 32'(overrun), 0);

    e0 = en_cnt; v0 = vld_rise; b0 = busy_cnt;
    rx_serial = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_serial = 1'b1;
    repeat (CPB / 2 + 1) @(posedge clk);
    #1;
    chk("fs_busy_low", 32'(busy), 0);
    chk("fs_busy_seen", 32'(busy_cnt - b0 > 0), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("fs_en", 32'(en_cnt - e0), 0);
    chk("fs_vld", 32'(vld_rise - v0), 0);

    v0 = vld_rise; f0 = ferr_cnt;
    send_frame(4'b0110, 1'b0, 1'b0, 0);
    chk("fe_pulse", 32'(ferr_cnt - f0), 1);
    chk("fe_no_vld", 32'(vld_rise - v0), 0);
    send_frame(4'b1001, 1'b1, 1'b0, 0);
    chk("fe_next_word", 32'(cap_word), 32'h9);
    chk("fe_next_vld", 32'(vld_rise - v0), 1);

    wif.word_ready = 1'b0;
    send_frame(4'b1100, 1'b1, 1'b0, 0);
    chk("bp_vld", 32'(wif.word_valid), 1);
    chk("bp_word", 32'(wif.word_out), 32'hc);
    chk("bp_ovr0", 32'(overrun), 0);
    send_frame(4'b0011, 1'b1, 1'b0, 0);
    chk("ov_word", 32'(wif.word_out), 32'hc);
    chk("ov_vld", 32'(wif.word_valid), 1);
    chk("ov_ovr", 32'(overrun), 1);
    wif.word_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ov_vld_clr", 32'(wif.word_valid), 0);
    chk("ov_sticky", 32'(overrun), 1);

    s0 = set_cnt;
    fill_req = 1'b1;
    @(posedge clk);
    #1;
    fill_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("fill_pulse", 32'(set_cnt - s0), 1);
    chk("fill_no_en", 32'(set_en_cnt), 0);
    chk("fill_idle", 32'(busy), 0);

    s0 = set_cnt; v0 = vld_rise;
    send_frame(4'b1110, 1'b1, 1'b1, 0);
    chk("prio_no_fill", 32'(set_cnt - s0), 0);
    chk("prio_word", 32'(cap_word), 32'he);
    chk("prio_vld", 32'(vld_rise - v0), 1);

    wif.word_ready = 1'b0;
    @(posedge clk);
    #1;
    wif.word_ready = 1'b1;
    v0 = vld_rise;
    send_frame(4'b0110, 1'b1, 1'b0, 2);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    rx_serial = 1'b1;
    fill_req = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_hold_busy", 32'(busy), 0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_partial", 32'(vld_rise - v0), 0);
    send_frame(4'b0101, 1'b1, 1'b0, 0);
    chk("post_word", 32'(cap_word), 32'h5);
    chk("post_vld", 32'(vld_rise - v0), 1);
    chk("post_ovr", 32'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
